mem_lsu: RTL and testbench

//  Load/store unit between the CPU execute stage and the word-wide synchronous memory.

---
 rtl/mem_lsu_if.sv | 37 +++
 rtl/mem_lsu.sv | 160 ++++++++++++++++
 tb/tb_mem_lsu.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Request, response and memory-side bus of the load/store unit.
// master: execute stage plus memory; slave: the LSU itself.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault_misalign;
    logic        rsp_fault_timeout;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wstrobe;
    logic        mem_rstrobe;
    logic [31:0] mem_rdata;
    logic        mem_done;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_done,
        input  req_ready, rsp_valid, rsp_rdata,
        input  rsp_fault_misalign, rsp_fault_timeout,
        input  mem_addr, mem_wdata, mem_wmask, mem_wstrobe, mem_rstrobe
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_done,
        output req_ready, rsp_valid, rsp_rdata,
        output rsp_fault_misalign, rsp_fault_timeout,
        output mem_addr, mem_wdata, mem_wmask, mem_wstrobe, mem_rstrobe
    );
endinterface

// File: rtl/mem_lsu.sv
// Byte/half/word load-store unit for a word-wide synchronous memory.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned accesses without touching memory.
module mem_lsu #(
    parameter int WAIT_TIMEOUT = 16
) (
    input logic      clk,
    input logic      rst,
    mem_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam int CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    state_e        state_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wmask_q;
    logic          wstb_q;
    logic          rstb_q;
    logic          ready_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic          fmis_q;
    logic          fto_q;

    logic [1:0]    off_d;
    logic [3:0]    wmask_d;
    logic [31:0]   wdata_d;
    logic          mis_d;
    logic [31:0]   sh_d;
    logic [31:0]   ldata_d;

    // Halves use lanes {a[1],0} and words lane 0 even when misaligned.
    always_comb begin
        off_d   = 2'b00;
        wmask_d = 4'b1111;
        wdata_d = bus.req_wdata;
        mis_d   = 1'b0;
        unique case (bus.req_funct3[1:0])
            2'b00: begin
                off_d   = bus.req_addr[1:0];
                wmask_d = 4'b0001 << bus.req_addr[1:0];
                wdata_d = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                off_d   = {bus.req_addr[1], 1'b0};
                wmask_d = 4'b0011 << {bus.req_addr[1], 1'b0};
                wdata_d = {2{bus.req_wdata[15:0]}};
                mis_d   = bus.req_addr[0];
            end
            default: begin
                mis_d   = |bus.req_addr[1:0];
            end
        endcase
    end

    always_comb begin
        sh_d    = bus.mem_rdata >> {off_q, 3'b000};
        ldata_d = sh_d;
        unique case (f3_q[1:0])
            2'b00:   ldata_d = {{24{~f3_q[2] & sh_d[7]}}, sh_d[7:0]};
            2'b01:   ldata_d = {{16{~f3_q[2] & sh_d[15]}}, sh_d[15:0]};
            default: ldata_d = sh_d;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            wstb_q   <= 1'b0;
            rstb_q   <= 1'b0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            fmis_q   <= 1'b0;
            fto_q    <= 1'b0;
        end else begin
            wstb_q   <= 1'b0;
            rstb_q   <= 1'b0;
            rvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        ready_q <= 1'b0;
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        off_q   <= off_d;
                        if (MIS_EN && mis_d) begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= '0;
                            fmis_q   <= 1'b1;
                            fto_q    <= 1'b0;
                        end else begin
                            state_q <= ISSUE;
                            addr_q  <= {bus.req_addr[31:2], 2'b00};
                            wdata_q <= bus.req_we ? wdata_d : '0;
                            wmask_q <= bus.req_we ? wmask_d : 4'b0000;
                            wstb_q  <= bus.req_we;
                            rstb_q  <= ~bus.req_we;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    if (bus.mem_done) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= we_q ? '0 : ldata_d;
                        fmis_q   <= 1'b0;
                        fto_q    <= 1'b0;
                    end else if (WAIT_TIMEOUT != 0 &&
                                 cnt_q == CW'(WAIT_TIMEOUT - 1)) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= '0;
                        fmis_q   <= 1'b0;
                        fto_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready          = ready_q;
    assign bus.rsp_valid          = rvalid_q;
    assign bus.rsp_rdata          = rdata_q;
    assign bus.rsp_fault_misalign = MIS_EN ? fmis_q : 1'b0;
    assign bus.rsp_fault_timeout  = fto_q;
    assign bus.mem_addr           = addr_q;
    assign bus.mem_wdata          = wdata_q;
    assign bus.mem_wmask          = wmask_q;
    assign bus.mem_wstrobe        = wstb_q;
    assign bus.mem_rstrobe        = rstb_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a byte-array reference memory.
// Honours LSU_MISALIGN_CHECK_EN when compiled with it.
module tb_mem_lsu;
    localparam int WT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_lsu_if bus();

    mem_lsu #(.WAIT_TIMEOUT(WT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  ref_mem [256];
    logic [7:0]  dmem    [256];
    logic [31:0] last_rd;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [3:0]  last_mask;
    int          last_nstb;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] ea);
        int sz;
        logic [31:0] v;
        sz = size_of(f3);
        v = '0;
        for (int i = 0; i < sz; i++)
            v = v | (32'(ref_mem[ea[7:0] + 8'(i)]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1])
            v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic run_op(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int dly);
        int sz, lat, exp_lat;
        bit got, exp_mis, exp_to;
        logic [31:0] ea, exp_rd, exp_wd;
        logic [3:0] exp_m;
        sz = size_of(f3);
        ea = a & ~(32'(sz) - 32'd1);
`ifdef LSU_MISALIGN_CHECK_EN
        exp_mis = (ea != a);
`else
        exp_mis = 1'b0;
`endif
        exp_to = !exp_mis && dly >= WT;
        exp_lat = exp_mis ? 1 : exp_to ? WT + 2 : 3 + dly;
        exp_m = '0;
        for (int i = 0; i < sz; i++) exp_m[int'(ea[1:0]) + i] = 1'b1;
        exp_wd = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
        exp_rd = (we || exp_mis || exp_to) ? 32'd0 : ref_load(f3, ea);
        if (we && !exp_mis)
            for (int i = 0; i < sz; i++)
                ref_mem[ea[7:0] + 8'(i)] = d[8*i +: 8];
        last_addr = 32'hFFFF_FFFF;
        last_nstb = 0;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            bus.req_valid = 1'b0;
            if (bus.mem_wstrobe || bus.mem_rstrobe) begin
                last_nstb++;
                last_addr = bus.mem_addr;
                chk({tag, "_dir"}, 32'(bus.mem_wstrobe), 32'(we));
                chk({tag, "_slat"}, lat, 1);
                chk({tag, "_maddr"}, bus.mem_addr, a & ~32'd3);
                if (bus.mem_wstrobe) begin
                    last_mask  = bus.mem_wmask;
                    last_wdata = bus.mem_wdata;
                    chk({tag, "_mask"}, 32'(bus.mem_wmask), 32'(exp_m));
                    chk({tag, "_wdata"}, bus.mem_wdata, exp_wd);
                    for (int i = 0; i < 4; i++)
                        if (bus.mem_wmask[i])
                            dmem[{bus.mem_addr[7:2], 2'(i)}] =
                                bus.mem_wdata[8*i +: 8];
                end
            end
            if (bus.rsp_valid) begin
                got = 1'b1;
                last_rd = bus.rsp_rdata;
                chk({tag, "_lat"}, lat, exp_lat);
                chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
                chk({tag, "_fmis"}, 32'(bus.rsp_fault_misalign), 32'(exp_mis));
                chk({tag, "_fto"}, 32'(bus.rsp_fault_timeout), 32'(exp_to));
            end else begin
                if (lat == 2)
                    bus.mem_rdata = {dmem[{bus.mem_addr[7:2], 2'd3}],
                                     dmem[{bus.mem_addr[7:2], 2'd2}],
                                     dmem[{bus.mem_addr[7:2], 2'd1}],
                                     dmem[{bus.mem_addr[7:2], 2'd0}]};
                bus.mem_done = (lat == 2 + dly);
            end
        end
        bus.mem_done = 1'b0;
        chk({tag, "_rsp"}, 32'(got), 32'd1);
        chk({tag, "_nstb"}, last_nstb, exp_mis ? 0 : 1);
    endtask

    initial begin
        logic [2:0] ftab [5];
        logic [2:0] f3;
        logic [31:0] a;
        logic we;
        int dly;
        ftab[0] = 3'b000; ftab[1] = 3'b001; ftab[2] = 3'b010;
        ftab[3] = 3'b100; ftab[4] = 3'b101;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom());
            dmem[i]    = ref_mem[i];
        end
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_rdata  = '0;
        bus.mem_done   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rvalid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_strobes", 32'({bus.mem_wstrobe, bus.mem_rstrobe}), 32'd0);
        chk("rst_maddr", bus.mem_addr, 32'd0);
        chk("rst_mask", 32'(bus.mem_wmask), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_faults",
            32'({bus.rsp_fault_misalign, bus.rsp_fault_timeout}), 32'd0);

        run_op("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        chk("sw10_m", 32'(last_mask), 32'hF);
        chk("sw10_d", last_wdata, 32'hDEAD_BEEF);
        run_op("sb13", 1'b1, 3'b000, 32'h13, 32'h0000_00A5, 1);
        chk("sb13_m", 32'(last_mask), 32'h8);
        chk("sb13_d", last_wdata, 32'hA5A5_A5A5);
        run_op("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 0);
        chk("lb13_v", last_rd, 32'hFFFF_FFA5);
        run_op("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 2);
        chk("lbu13_v", last_rd, 32'h0000_00A5);
        run_op("sh22", 1'b1, 3'b001, 32'h22, 32'h0000_8001, 0);
        chk("sh22_m", 32'(last_mask), 32'hC);
        run_op("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 0);
        chk("lh22_v", last_rd, 32'hFFFF_8001);
        run_op("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 0);
        chk("lhu22_v", last_rd, 32'h0000_8001);
        run_op("lw06", 1'b0, 3'b010, 32'h06, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lw06_fault", 32'(bus.rsp_fault_misalign), 32'd1);
`else
        chk("lw06_addr", last_addr, 32'h04);
`endif

        run_op("lwto", 1'b0, 3'b010, 32'h40, 32'h0, 1000);
        chk("lwto_fto", 32'(bus.rsp_fault_timeout), 32'd1);
        @(negedge clk);
        chk("lwto_ready", 32'(bus.req_ready), 32'd1);
        bus.mem_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_done_rv", 32'(bus.rsp_valid), 32'd0);
        end
        bus.mem_done = 1'b0;

        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h80;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_strobes", 32'({bus.mem_wstrobe, bus.mem_rstrobe}), 32'd0);
        chk("arst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        run_op("lw_after_rst", 1'b0, 3'b010, 32'h80, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            we  = 1'($urandom_range(0, 1));
            f3  = we ? ftab[$urandom_range(0, 2)] : ftab[$urandom_range(0, 4)];
            a   = $urandom();
            if ($urandom_range(0, 7) != 0)
                a = a & ~(32'(size_of(f3)) - 32'd1);
            dly = $urandom_range(0, 3);
            if (!we && $urandom_range(0, 19) == 0) dly = WT + 4;
            run_op("rnd", we, f3, a, $urandom(), dly);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
